// File: rtl/hdmi_pll_sequencer_if.sv
// ---------------------------------------------------------------------------
// hdmi_pll_sequencer_if
// Control/status bundle between the bus logic, the HDMI clock-recovery PLL
// and hdmi_pll_sequencer.
//
// Signals:
//   i_enable        software enable; low forces the sequencer idle
//   i_restart       single-cycle pulse requesting a fresh power-cycle
//   i_pll_locked    PLL LOCKED, asynchronous to the system clock
//   o_pll_ce        PLL enable; low powers the PLL down and holds it in reset
//   o_ready         recovered clocks usable
//   o_state         current sequencer state code
//   o_int           one-cycle pulse on lock loss from READY
//   o_loss_count    saturating count of lock losses from READY
//   o_timeout_count saturating count of lock timeouts
//
// Modports:
//   slave  - the sequencer side
//   master - the controller / bench side
// ---------------------------------------------------------------------------
interface hdmi_pll_sequencer_if #(
  parameter int STAT_W = 16
) ();
  logic              i_enable;
  logic              i_restart;
  logic              i_pll_locked;
  logic              o_pll_ce;
  logic              o_ready;
  logic [2:0]        o_state;
  logic              o_int;
  logic [STAT_W-1:0] o_loss_count;
  logic [STAT_W-1:0] o_timeout_count;

  modport slave (
    input  i_enable, i_restart, i_pll_locked,
    output o_pll_ce, o_ready, o_state, o_int, o_loss_count, o_timeout_count
  );

  modport master (
    output i_enable, i_restart, i_pll_locked,
    input  o_pll_ce, o_ready, o_state, o_int, o_loss_count, o_timeout_count
  );
endinterface

// File: rtl/hdmi_pll_sequencer.sv
// ---------------------------------------------------------------------------
// hdmi_pll_sequencer
// Supervises the HDMI receive clock-recovery PLL from the system clock.
// Power-cycles the PLL, waits for lock, requires lock to hold for a settle
// interval, then declares the recovered clocks ready. Lock timeouts and lock
// losses trigger a retry and are tallied in saturating counters.
//
// Parameters:
//   OFF_CYCLES     cycles o_pll_ce is held low before each attempt (>= 2)
//   LOCK_TIMEOUT   cycles allowed for synchronized lock (>= 2)
//   SETTLE_CYCLES  cycles lock must hold continuously before ready (>= 1)
//   CW             width of the shared down-counter
//   STAT_W         width of the event counters (16 for the status register)
//
// Ports:
//   i_clk    system clock, the only clock
//   i_reset  synchronous active-high reset
//   bus      control/status bundle (slave modport), see the interface file
// ---------------------------------------------------------------------------
module hdmi_pll_sequencer #(
  parameter int OFF_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 1048576,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CW            = 24,
  parameter int STAT_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  hdmi_pll_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    OFF       = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    READY     = 3'd4
  } state_e;

  localparam logic [CW-1:0]     OFF_LOAD    = CW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0]     LOCK_LOAD   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]     SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [STAT_W-1:0] STAT_MAX    = '1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sync_q, lck;
  logic              pll_ce_q, ready_q, int_q;
  logic              int_d, loss_inc, timeout_inc;
  logic [STAT_W-1:0] loss_q, timeout_q;

  // Next-state logic. Disable and restart override every state transition;
  // the shared down-counter is reloaded on entry to each timed state.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    int_d       = 1'b0;
    loss_inc    = 1'b0;
    timeout_inc = 1'b0;

    if (!bus.i_enable) begin
      state_d = IDLE;
    end else if (bus.i_restart) begin
      state_d = OFF;
      cnt_d   = OFF_LOAD;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = OFF;
          cnt_d   = OFF_LOAD;
        end
        OFF: begin
          if (cnt_q == '0) begin
            state_d = WAIT_LOCK;
            cnt_d   = LOCK_LOAD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock arriving on the last timeout cycle still wins.
          if (lck) begin
            state_d = SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else if (cnt_q == '0) begin
            timeout_inc = 1'b1;
            state_d     = OFF;
            cnt_d       = OFF_LOAD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        SETTLE: begin
          // A glitch while settling just restarts the lock wait; it is not
          // counted as a loss.
          if (!lck) begin
            state_d = WAIT_LOCK;
            cnt_d   = LOCK_LOAD;
          end else if (cnt_q == '0) begin
            state_d = READY;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        READY: begin
          if (!lck) begin
            loss_inc = 1'b1;
            int_d    = 1'b1;
            state_d  = OFF;
            cnt_d    = OFF_LOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registers. Outputs are decoded from the next state so they line up with
  // the state register without a combinational path to the pins.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sync_q    <= 1'b0;
      lck       <= 1'b0;
      pll_ce_q  <= 1'b0;
      ready_q   <= 1'b0;
      int_q     <= 1'b0;
      loss_q    <= '0;
      timeout_q <= '0;
    end else begin
      // Two-flop synchronizer for the asynchronous LOCKED input.
      sync_q    <= bus.i_pll_locked;
      lck       <= sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_ce_q  <= (state_d == WAIT_LOCK) || (state_d == SETTLE) ||
                   (state_d == READY);
      ready_q   <= (state_d == READY);
      int_q     <= int_d;
      if (loss_inc && (loss_q != STAT_MAX)) begin
        loss_q <= loss_q + STAT_W'(1);
      end
      if (timeout_inc && (timeout_q != STAT_MAX)) begin
        timeout_q <= timeout_q + STAT_W'(1);
      end
    end
  end

  assign bus.o_pll_ce        = pll_ce_q;
  assign bus.o_ready         = ready_q;
  assign bus.o_state         = state_q;
  assign bus.o_int           = int_q;
  assign bus.o_loss_count    = loss_q;
  assign bus.o_timeout_count = timeout_q;

endmodule
